friscv_dmem_resp: RTL

Data-memory responder for the FRiscV core. It sits on the far side of the core's data-memory port: it accepts address, write-data and write-enable from the CPU, and returns read data. It contains a word-organised synchronous RAM plus an optional memory-mapped I/O window. The window holds a 64-bit free-running cycle counter with tear-free high-word reads and a GPIO output register.

---
 rtl/friscv_dmem_resp.sv | 101 ++++++++++
 1 files changed

// File: rtl/friscv_dmem_resp.sv
// rtl/friscv_dmem_resp.sv - FRiscV data-memory responder: word RAM plus optional MMIO window
// Optional MMIO window (cycle counter, hi_shadow, GPIO) is built only with FRISCV_DMEM_MMIO_EN defined.

package friscv_sv_pkg;
   parameter int ARCH = 32;
endpackage

module friscv_dmem_resp
   import friscv_sv_pkg::*;
#(
   parameter int              DEPTH     = 1024,
   parameter logic [ARCH-1:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ARCH-1:0] d_mem_addr_in,
   input  logic [ARCH-1:0] d_mem_wd_in,
   input  logic            d_mem_we_in,
   output logic [ARCH-1:0] d_mem_rd_out,
   output logic            d_mem_err_out,
   output logic [ARCH-1:0] gpio_out
);

   localparam int              AW        = $clog2(DEPTH);
   localparam logic [ARCH-1:0] RAM_BYTES = ARCH'(DEPTH * 4);

   logic [ARCH-1:0] mem [DEPTH];
   logic [AW-1:0]   ram_idx;
   logic            misaligned;
   logic            in_ram;
   logic            in_mmio;
   logic            acc_err;
   logic [ARCH-1:0] mmio_rd;

   assign misaligned = d_mem_addr_in[1:0] != 2'b00;
   assign in_ram     = d_mem_addr_in < RAM_BYTES;
   assign ram_idx    = d_mem_addr_in[AW+1:2];
   assign acc_err    = misaligned | ~(in_ram | in_mmio);

`ifdef FRISCV_DMEM_MMIO_EN
   logic [63:0]     cycle_cnt;
   logic [ARCH-1:0] hi_shadow;
   logic [ARCH-1:0] gpio_q;
   logic [ARCH-1:0] mmio_off;

   // Offset form avoids overflow of MMIO_BASE+16 when the base sits near the top.
   assign mmio_off = d_mem_addr_in - MMIO_BASE;
   assign in_mmio  = (d_mem_addr_in >= MMIO_BASE) && (mmio_off < ARCH'(16));
   assign gpio_out = gpio_q;

   always_comb begin
      mmio_rd = '0;
      case (mmio_off[3:2])
         2'd0:    mmio_rd = cycle_cnt[31:0];
         2'd1:    mmio_rd = hi_shadow;
         2'd2:    mmio_rd = gpio_q;
         default: mmio_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         hi_shadow <= '0;
         gpio_q    <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (!acc_err && in_mmio && mmio_off[3:2] == 2'd0)
            hi_shadow <= cycle_cnt[63:32];
         if (!acc_err && in_mmio && mmio_off[3:2] == 2'd2 && d_mem_we_in)
            gpio_q <= d_mem_wd_in;
      end
   end
`else
   assign in_mmio  = 1'b0;
   assign mmio_rd  = '0;
   assign gpio_out = '0;
`endif

   // Contents are deliberately not reset; writes seen during reset are dropped.
   always_ff @(posedge clk) begin
      if (rst_n && d_mem_we_in && in_ram && !misaligned)
         mem[ram_idx] <= d_mem_wd_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_mem_rd_out  <= '0;
         d_mem_err_out <= 1'b0;
      end else begin
         d_mem_err_out <= acc_err;
         if (acc_err)
            d_mem_rd_out <= '0;
         else if (in_ram)
            d_mem_rd_out <= mem[ram_idx];
         else
            d_mem_rd_out <= mmio_rd;
      end
   end

endmodule
